// File: rtl/wb_regbank_pkg.sv
// Shared widths and helpers for the Wishbone register bank.
// Byte-lane mask expansion and word-address to register-index mapping.
package wb_regbank_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    function automatic logic [WB_DATA_W-1:0] sel_to_mask(input logic [WB_SEL_W-1:0] sel);
        logic [WB_DATA_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < WB_SEL_W; b++) begin
            mask[b*8 +: 8] = {8{sel[b]}};
        end
        return mask;
    endfunction

    // Callers pass the zero-extended word address (byte address bits [1:0] already dropped).
    function automatic int unsigned reg_index(input logic [31:0] word_adr);
        return word_adr;
    endfunction

endpackage

// File: rtl/wb_regbank_if.sv
// Wishbone pipelined slave front end: accept/in-progress flag, ack/err generation, read stages.
// Write ack in cycle 1, read ack in cycle 1 (+RD_PIPE); stall while a request waits for its ack/err.
module wb_regbank_if
    import wb_regbank_pkg::*;
#(
    parameter int NREGS   = 4,
    parameter int ADDR_W  = 2,
    parameter int RD_PIPE = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [ADDR_W-1:0]    wb_adr_i,
    input  logic [WB_SEL_W-1:0]  wb_sel_i,
    input  logic                 wb_we_i,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    output logic                 wb_stall_o,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    input  logic [WB_DATA_W-1:0] rd_data,
    output logic                 wr_go,
    output logic [ADDR_W-1:0]    wr_adr,
    output logic [WB_DATA_W-1:0] wr_dat,
    output logic [WB_SEL_W-1:0]  wr_sel
);

    localparam int unsigned NREGS_U = NREGS;

    logic                 wb_en, accept, rd_acc, wr_acc, rd_hit, wr_hit;
    logic                 busy_q, wr_q, rd_ack_q, rd_err_q;
    logic [WB_DATA_W-1:0] rd_dat_q;
    logic [ADDR_W-1:0]    wr_adr_q;
    logic [WB_DATA_W-1:0] wr_dat_q;
    logic [WB_SEL_W-1:0]  wr_sel_q;
    logic                 rd_ack_s, rd_err_s;
    logic [WB_DATA_W-1:0] rd_dat_s;

    assign wb_en  = wb_cyc_i & wb_stb_i;
    assign accept = wb_en & ~busy_q;
    assign rd_acc = accept & ~wb_we_i;
    assign wr_acc = accept & wb_we_i;
    assign rd_hit = reg_index(32'(wb_adr_i)) < NREGS_U;
    assign wr_hit = reg_index(32'(wr_adr_q)) < NREGS_U;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            rd_dat_q <= '0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
            wr_sel_q <= '0;
        end else begin
            if (accept) begin
                busy_q <= 1'b1;
            end else if (wb_ack_o | wb_err_o) begin
                busy_q <= 1'b0;
            end
            wr_q     <= wr_acc;
            rd_ack_q <= rd_acc & rd_hit;
            rd_err_q <= rd_acc & ~rd_hit;
            rd_dat_q <= (rd_acc & rd_hit) ? rd_data : '0;
            if (wr_acc) begin
                wr_adr_q <= wb_adr_i;
                wr_dat_q <= wb_dat_i;
                wr_sel_q <= wb_sel_i;
            end
        end
    end

    if (RD_PIPE != 0) begin : g_rd_pipe
        logic                 ack_p, err_p;
        logic [WB_DATA_W-1:0] dat_p;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ack_p <= 1'b0;
                err_p <= 1'b0;
                dat_p <= '0;
            end else begin
                ack_p <= rd_ack_q;
                err_p <= rd_err_q;
                dat_p <= rd_dat_q;
            end
        end
        assign rd_ack_s = ack_p;
        assign rd_err_s = err_p;
        assign rd_dat_s = dat_p;
    end else begin : g_rd_direct
        assign rd_ack_s = rd_ack_q;
        assign rd_err_s = rd_err_q;
        assign rd_dat_s = rd_dat_q;
    end

    // Only one transaction is ever outstanding, so read and write responses never overlap.
    assign wb_ack_o   = (wr_q & wr_hit) | rd_ack_s;
    assign wb_err_o   = (wr_q & ~wr_hit) | rd_err_s;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = wb_en & ~(wb_ack_o | wb_err_o);
    assign wb_dat_o   = rd_dat_s;

    assign wr_go  = wr_q & wr_hit;
    assign wr_adr = wr_adr_q;
    assign wr_dat = wr_dat_q;
    assign wr_sel = wr_sel_q;

endmodule

// File: rtl/wb_regbank_gen.sv
// Parametrised Wishbone register bank: RW/RO registers, field masks, write strobes one cycle after ack.
// WB_REGBANK_SHADOW_EN: writes land in shadows, committed to live by bit 31 of the last register.
module wb_regbank_gen
    import wb_regbank_pkg::*;
#(
    parameter int                  NREGS      = 4,
    parameter int                  ADDR_W     = 2,
    parameter logic [NREGS-1:0]    RO_MASK    = '0,
    parameter logic [NREGS*32-1:0] FIELD_MASK = '1,
    parameter logic [NREGS*32-1:0] RESET_VAL  = '0,
    parameter int                  RD_PIPE    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic                  wb_stall_o,
    output logic [31:0]           wb_dat_o,
    output logic [NREGS*32-1:0]   regs_o,
    input  logic [NREGS*32-1:0]   regs_i,
    output logic [NREGS-1:0]      wr_strb_o
);

    logic                 wr_go;
    logic [ADDR_W-1:0]    wr_adr;
    logic [WB_DATA_W-1:0] wr_dat;
    logic [WB_SEL_W-1:0]  wr_sel;
    logic [WB_DATA_W-1:0] rd_data;
    logic [WB_DATA_W-1:0] wr_bmask;
    int unsigned          rd_idx, wr_idx;

    logic [WB_DATA_W-1:0] live_q [NREGS];
    logic [WB_DATA_W-1:0] view   [NREGS];
    logic [WB_DATA_W-1:0] wr_val [NREGS];
    logic [NREGS-1:0]     wr_en;
    logic [NREGS-1:0]     strb_q;

    wb_regbank_if #(
        .NREGS   (NREGS),
        .ADDR_W  (ADDR_W),
        .RD_PIPE (RD_PIPE)
    ) u_if (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_adr_i   (wb_adr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_rty_o   (wb_rty_o),
        .wb_stall_o (wb_stall_o),
        .wb_dat_o   (wb_dat_o),
        .rd_data    (rd_data),
        .wr_go      (wr_go),
        .wr_adr     (wr_adr),
        .wr_dat     (wr_dat),
        .wr_sel     (wr_sel)
    );

    assign rd_idx   = reg_index(32'(wb_adr_i));
    assign wr_idx   = reg_index(32'(wr_adr));
    assign wr_bmask = sel_to_mask(wr_sel);

    // Only selected lanes that are also implemented bits take the new data.
    always_comb begin
        wr_en = '0;
        for (int k = 0; k < NREGS; k++) begin
            wr_en[k]  = wr_go && (wr_idx == k) && !RO_MASK[k];
            wr_val[k] = (view[k] & ~(wr_bmask & FIELD_MASK[k*32 +: 32]))
                      | (wr_dat & wr_bmask & FIELD_MASK[k*32 +: 32]);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (rd_idx == k) begin
                rd_data = RO_MASK[k] ? (regs_i[k*32 +: 32] & FIELD_MASK[k*32 +: 32]) : view[k];
            end
        end
    end

`ifdef WB_REGBANK_SHADOW_EN
    logic [WB_DATA_W-1:0] shadow_q   [NREGS];
    logic [WB_DATA_W-1:0] shadow_nxt [NREGS];
    logic                 commit;

    assign commit = wr_en[NREGS-1] && wr_dat[31] && wr_sel[3];
    assign view   = shadow_q;

    always_comb begin
        for (int k = 0; k < NREGS; k++) begin
            shadow_nxt[k] = wr_en[k] ? wr_val[k] : shadow_q[k];
        end
        if (commit) begin
            shadow_nxt[NREGS-1][31] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREGS; k++) begin
                live_q[k]   <= RESET_VAL[k*32 +: 32] & FIELD_MASK[k*32 +: 32];
                shadow_q[k] <= RESET_VAL[k*32 +: 32] & FIELD_MASK[k*32 +: 32];
            end
            strb_q <= '0;
        end else begin
            strb_q <= '0;
            for (int k = 0; k < NREGS; k++) begin
                shadow_q[k] <= shadow_nxt[k];
                if (commit && !RO_MASK[k]) begin
                    live_q[k] <= shadow_nxt[k];
                    strb_q[k] <= (live_q[k] != shadow_nxt[k]);
                end
            end
        end
    end
`else
    assign view = live_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREGS; k++) begin
                live_q[k] <= RESET_VAL[k*32 +: 32] & FIELD_MASK[k*32 +: 32];
            end
            strb_q <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (wr_en[k]) begin
                    live_q[k] <= wr_val[k];
                end
            end
            strb_q <= wr_en;
        end
    end
`endif

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_o
        assign regs_o[g*32 +: 32] = RO_MASK[g] ? 32'h0 : live_q[g];
    end

    assign wr_strb_o = strb_q;

endmodule

// File: tb/tb_wb_regbank_gen.sv
// Directed checks of three wb_regbank_gen configurations; shadow expectations follow WB_REGBANK_SHADOW_EN.
module tb_wb_regbank_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb [3];
    logic [1:0]  adr = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic [31:0] wdat = '0;

    logic        ack [3];
    logic        err [3];
    logic        rty [3];
    logic        stall [3];
    logic [31:0] rdat [3];

    logic [127:0] regs_a, regs_b;
    logic [95:0]  regs_c;
    logic [127:0] rin_a = '0;
    logic [127:0] rin_b = {32'h1234_5678, 96'h0};
    logic [95:0]  rin_c = {32'hA5A5_0F0F, 64'h0};
    logic [3:0]   strb_a, strb_b;
    logic [2:0]   strb_c;

    int n_cmp = 0;
    int n_fail = 0;

    int          r_lat;
    logic        r_ack, r_err;
    logic [31:0] r_dat;

    always #5 clk = ~clk;

    wb_regbank_gen #(
        .NREGS(4), .ADDR_W(2), .RO_MASK(4'b0000),
        .FIELD_MASK({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF}),
        .RESET_VAL({32'h0, 32'h0, 32'h0000_00A5, 32'h0}), .RD_PIPE(0)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(stb[0]), .wb_stb_i(stb[0]), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
        .wb_rty_o(rty[0]), .wb_stall_o(stall[0]), .wb_dat_o(rdat[0]), .regs_o(regs_a),
        .regs_i(rin_a), .wr_strb_o(strb_a)
    );

    wb_regbank_gen #(
        .NREGS(4), .ADDR_W(2), .RO_MASK(4'b1000),
        .FIELD_MASK({128{1'b1}}),
        .RESET_VAL({32'h0, 32'h0, 32'h0000_00A5, 32'h0}), .RD_PIPE(1)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(stb[1]), .wb_stb_i(stb[1]), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
        .wb_rty_o(rty[1]), .wb_stall_o(stall[1]), .wb_dat_o(rdat[1]), .regs_o(regs_b),
        .regs_i(rin_b), .wr_strb_o(strb_b)
    );

    wb_regbank_gen #(
        .NREGS(3), .ADDR_W(2), .RO_MASK(3'b100),
        .FIELD_MASK({96{1'b1}}), .RESET_VAL({96{1'b0}}), .RD_PIPE(0)
    ) u_c (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(stb[2]), .wb_stb_i(stb[2]), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(wdat), .wb_ack_o(ack[2]), .wb_err_o(err[2]),
        .wb_rty_o(rty[2]), .wb_stall_o(stall[2]), .wb_dat_o(rdat[2]), .regs_o(regs_c),
        .regs_i(rin_c), .wr_strb_o(strb_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One-cycle strobe (cycle 0), then wait up to 6 cycles for ack/err; r_lat counts cycles after edge 1.
    task automatic xfer(input int i, input logic w, input logic [1:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        @(negedge clk);
        adr = a; sel = s; we = w; wdat = d; stb[i] = 1'b1;
        @(negedge clk);
        stb[i] = 1'b0;
        r_lat = 1;
        while (!(ack[i] || err[i]) && r_lat < 7) begin
            @(negedge clk);
            r_lat++;
        end
        r_ack = ack[i]; r_err = err[i]; r_dat = rdat[i];
    endtask

    typedef struct {
        int          inst;
        logic        we;
        logic [1:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [22];

    initial begin
        vecs[0]  = '{0, 1'b0, 2'd0, 4'hF, 32'h0,         1'b0, 1, 32'h0000_0000};
        vecs[1]  = '{0, 1'b0, 2'd1, 4'hF, 32'h0,         1'b0, 1, 32'h0000_00A5};
        vecs[2]  = '{0, 1'b0, 2'd2, 4'hF, 32'h0,         1'b0, 1, 32'h0000_0000};
        vecs[3]  = '{0, 1'b0, 2'd3, 4'hF, 32'h0,         1'b0, 1, 32'h0000_0000};
        vecs[4]  = '{0, 1'b1, 2'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1, 32'h0};
        vecs[5]  = '{0, 1'b0, 2'd0, 4'hF, 32'h0,         1'b0, 1, 32'h0000_BEEF};
        vecs[6]  = '{0, 1'b1, 2'd2, 4'h4, 32'h1122_3344, 1'b0, 1, 32'h0};
        vecs[7]  = '{0, 1'b0, 2'd2, 4'hF, 32'h0,         1'b0, 1, 32'h0022_0000};
        vecs[8]  = '{0, 1'b1, 2'd1, 4'h0, 32'hFFFF_FFFF, 1'b0, 1, 32'h0};
        vecs[9]  = '{0, 1'b0, 2'd1, 4'hF, 32'h0,         1'b0, 1, 32'h0000_00A5};
        vecs[10] = '{0, 1'b1, 2'd1, 4'h3, 32'hCAFE_1234, 1'b0, 1, 32'h0};
        vecs[11] = '{0, 1'b0, 2'd1, 4'hF, 32'h0,         1'b0, 1, 32'h0000_1234};
        vecs[12] = '{1, 1'b0, 2'd3, 4'hF, 32'h0,         1'b0, 2, 32'h1234_5678};
        vecs[13] = '{1, 1'b0, 2'd0, 4'hF, 32'h0,         1'b0, 2, 32'h0000_0000};
        vecs[14] = '{1, 1'b0, 2'd1, 4'hF, 32'h0,         1'b0, 2, 32'h0000_00A5};
        vecs[15] = '{2, 1'b0, 2'd3, 4'hF, 32'h0,         1'b1, 1, 32'h0000_0000};
        vecs[16] = '{2, 1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 1'b1, 1, 32'h0};
        vecs[17] = '{2, 1'b0, 2'd2, 4'hF, 32'h0,         1'b0, 1, 32'hA5A5_0F0F};
        vecs[18] = '{2, 1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF, 1'b0, 1, 32'h0};
        vecs[19] = '{2, 1'b0, 2'd2, 4'hF, 32'h0,         1'b0, 1, 32'hA5A5_0F0F};
        vecs[20] = '{2, 1'b1, 2'd1, 4'hF, 32'h0BAD_F00D, 1'b0, 1, 32'h0};
        vecs[21] = '{2, 1'b0, 2'd1, 4'hF, 32'h0,         1'b0, 1, 32'h0BAD_F00D};

        for (int i = 0; i < 3; i++) stb[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ack_a", 32'(ack[0]), 32'h0);
        chk("rst err_a", 32'(err[0]), 32'h0);
        chk("rst rty_a", 32'(rty[0]), 32'h0);
        chk("rst dat_a", rdat[0], 32'h0);
        chk("rst strb_a", 32'(strb_a), 32'h0);
        chk("rst regs_a r1", regs_a[63:32], 32'h0000_00A5);
        chk("rst regs_a r0", regs_a[31:0], 32'h0);
        chk("rst ack_b", 32'(ack[1]), 32'h0);
        chk("rst regs_b r3 (RO)", regs_b[127:96], 32'h0);
        rst = 1'b0;

        // Table-driven transfers, issued back-to-back
        for (int i = 0; i < 22; i++) begin
            xfer(vecs[i].inst, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat);
            chk($sformatf("vec%0d latency", i), 32'(r_lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d err", i), 32'(r_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d ack", i), 32'(r_ack), 32'(!vecs[i].exp_err));
            if (!vecs[i].we) chk($sformatf("vec%0d rdata", i), r_dat, vecs[i].exp_dat);
        end

        // Write strobe timing and regs_o update
        xfer(0, 1'b1, 2'd0, 4'hF, 32'h0000_1111);
        chk("wr strb in ack cycle", 32'(strb_a), 32'h0);
        @(negedge clk);
`ifdef WB_REGBANK_SHADOW_EN
        chk("wr strb cycle2", 32'(strb_a), 32'h0);
        chk("wr regs_o r0 cycle2", regs_a[31:0], 32'h0);
`else
        chk("wr strb cycle2", 32'(strb_a), 32'h1);
        chk("wr regs_o r0 cycle2", regs_a[31:0], 32'h0000_1111);
`endif
        @(negedge clk);
        chk("wr strb cycle3", 32'(strb_a), 32'h0);

        // Unmapped write and RO write leave no strobe
        xfer(2, 1'b1, 2'd3, 4'hF, 32'h1);
        @(negedge clk);
        chk("err wr strb_c", 32'(strb_c), 32'h0);
        xfer(2, 1'b1, 2'd2, 4'hF, 32'h1);
        @(negedge clk);
        chk("ro wr strb_c", 32'(strb_c), 32'h0);
        chk("ro regs_o r2 zero", regs_c[95:64], 32'h0);

        // RD_PIPE=1 with strobe held: stall in cycles 0-1, ack in cycle 2
        @(negedge clk);
        adr = 2'd3; sel = 4'hF; we = 1'b0; stb[1] = 1'b1;
        #1;
        chk("pipe stall c0", 32'(stall[1]), 32'h1);
        @(negedge clk);
        chk("pipe stall c1", 32'(stall[1]), 32'h1);
        chk("pipe ack c1", 32'(ack[1]), 32'h0);
        @(negedge clk);
        chk("pipe ack c2", 32'(ack[1]), 32'h1);
        chk("pipe stall c2", 32'(stall[1]), 32'h0);
        chk("pipe dat c2", rdat[1], 32'h1234_5678);
        stb[1] = 1'b0;

        // Reset during a write's ack cycle drops the strobe and restores reset values
        @(negedge clk);
        adr = 2'd2; sel = 4'hF; we = 1'b1; wdat = 32'hFFFF_FFFF; stb[0] = 1'b1;
        @(negedge clk);
        stb[0] = 1'b0;
        chk("mid-rst ack before", 32'(ack[0]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-rst ack", 32'(ack[0]), 32'h0);
        chk("mid-rst strb", 32'(strb_a), 32'h0);
        chk("mid-rst regs r2", regs_a[95:64], 32'h0);
        chk("mid-rst regs r1", regs_a[63:32], 32'h0000_00A5);
        rst = 1'b0;
        xfer(0, 1'b0, 2'd1, 4'hF, 32'h0);
        chk("post-rst read r1", r_dat, 32'h0000_00A5);
        chk("post-rst read lat", 32'(r_lat), 32'h1);

`ifdef WB_REGBANK_SHADOW_EN
        xfer(0, 1'b1, 2'd0, 4'hF, 32'h5);
        @(negedge clk);
        chk("shd live r0 held", regs_a[31:0], 32'h0);
        chk("shd no strb", 32'(strb_a), 32'h0);
        xfer(0, 1'b1, 2'd3, 4'hF, 32'h8000_0000);
        @(negedge clk);
        chk("shd commit r0", regs_a[31:0], 32'h5);
        chk("shd commit strb", 32'(strb_a), 32'h1);
        xfer(0, 1'b0, 2'd3, 4'hF, 32'h0);
        chk("shd r3 bit31 clear", r_dat, 32'h0);
        xfer(0, 1'b0, 2'd0, 4'hF, 32'h0);
        chk("shd read r0", r_dat, 32'h5);
`else
        xfer(0, 1'b1, 2'd3, 4'hF, 32'h8000_0000);
        @(negedge clk);
        chk("live r3", regs_a[127:96], 32'h8000_0000);
        chk("live strb r3", 32'(strb_a), 32'h8);
        xfer(0, 1'b0, 2'd3, 4'hF, 32'h0);
        chk("read r3", r_dat, 32'h8000_0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regbank_gen.md
Name: wb_regbank_gen

Overview:
- Parametrised Wishbone classic-pipelined slave register bank.
- Successor to the fixed two-register generated blocks: NREGS 32-bit registers, each either RW (control) or RO (status from hardware).
- Per-register implemented-bit masks, write-strobe pulses, error response on unmapped addresses, optional extra read pipeline stage.
- Sits between the Wishbone interconnect and a peripheral's control/status logic.

Parameters:
- NREGS, 4, number of 32-bit registers; 1..2**ADDR_W.
- ADDR_W, 2, word-address width; wb_adr_i spans [ADDR_W+1:2].
- RO_MASK, 0, NREGS bits; bit k=1 makes register k read-only (reads regs_i slice k).
- FIELD_MASK, all ones, NREGS*32 bits; 0 bits are unimplemented: read 0, writes ignored, held at 0.
- RESET_VAL, 0, NREGS*32 bits; reset value of RW registers, ANDed with FIELD_MASK.
- RD_PIPE, 0, 0 or 1; number of extra registered read stages.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_adr_i  in  ADDR_W  word address [ADDR_W+1:2]
- wb_sel_i  in  4  byte selects
- wb_we_i  in  1  write enable
- wb_dat_i  in  32  write data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error (unmapped address)
- wb_rty_o  out  1  tied 0
- wb_stall_o  out  1  stall
- wb_dat_o  out  32  read data
- regs_o  out  NREGS*32  current RW register values; RO slices read 0
- regs_i  in  NREGS*32  status inputs for RO registers
- wr_strb_o  out  NREGS  one-cycle pulse per accepted register write

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values:
  - wb_ack_o, wb_err_o, wb_dat_o, wr_strb_o: 0.
  - RW registers: RESET_VAL & FIELD_MASK.
  - All pipeline and in-progress flags: cleared.
- Request (cycle 0): wb_en = cyc&stb. A read or write request is accepted only when its in-progress flag is clear. The flag is set on accept and cleared on that request's ack/err.
- wb_stall_o = wb_en & ~(ack|err). Only one transaction is outstanding.
- Write path:
  - Edge 1 registers request, address, data and sel.
  - Cycle 1: combinational decode; ack (or err) asserted.
  - Edge 2: byte lanes with sel=1 update masked bits.
  - Cycle 2: regs_o shows the new value; wr_strb_o[k] pulses for exactly 1 cycle.
- Read path:
  - Cycle 0: combinational decode of wb_adr_i.
  - Edge 1: wb_dat_o and ack/err registered; visible in cycle 1 (RD_PIPE=0) or cycle 2 (RD_PIPE=1).
  - Read data = register & FIELD_MASK. RO registers return regs_i slice & FIELD_MASK, sampled at edge 1.
- Unmapped index (>= NREGS): wb_err_o instead of ack, same latency; read data 0; no state change, no strobe.
- Writes to RO registers: acked normally, data discarded, no strobe.
- Boundaries:
  - sel=0000: acked, no bits change, strobe still pulses.
  - cyc deasserted mid-transaction: the ack is still produced; the master ignores it.
  - Reset mid-transaction: pending ack/err and strobe are dropped; registers return to reset values at that edge.
  - Back-to-back requests: the next request is accepted in the cycle after ack.

Optional Feature:
- Macro WB_REGBANK_SHADOW_EN.
- Defined:
  - Writes to RW registers go to shadow copies; regs_o is unchanged.
  - A write to index NREGS-1 with bit 31 set copies all shadows to live registers at the same edge. That register must be RW; bit 31 self-clears.
  - wr_strb_o pulses for every register whose live value changed by the commit.
  - Reads return the shadow value.
- Undefined: writes update live registers directly, as above.

Decomposition:
- Package wb_regbank_pkg:
  - WB_DATA_W=32 and WB_SEL_W=4.
  - Function expanding sel to a 32-bit byte mask.
  - Function computing the register index from the address.
- Sub-module wb_regbank_if holds the Wishbone request/ack pipeline, in-progress flags, stall, RD_PIPE stage and err mux. The top level holds the register array, decode and strobes.

Test Plan:
- Reset with NREGS=4, RESET_VAL reg1=0x0000_00A5 -> regs_o reg1=0xA5, reads of others return 0, all acks 0.
- Write 0xDEADBEEF to reg0, sel=1111, FIELD_MASK reg0=0x0000_FFFF -> ack in cycle 1, wr_strb_o[0] in cycle 2, read returns 0x0000_BEEF.
- Write 0x11223344 to reg2 with sel=0100 over 0 -> reg2=0x0022_0000.
- Read reg3 with RO_MASK=1000, regs_i reg3=0x1234_5678 -> 0x12345678; RD_PIPE=1 -> ack in cycle 2, stall high cycles 0-1.
- NREGS=3, ADDR_W=2, access index 3 -> wb_err_o in cycle 1, no ack, data 0, no strobe.
- Shadow build: write reg0=0x5, regs_o reg0 still 0; write reg3 bit31 -> next cycle regs_o reg0=0x5, wr_strb_o[0]=1, reg3 bit31 reads 0.
